// File: rtl/sram_rgb_pixel_reader.sv
// Streams a packed RGB888 frame out of SRAM (2 pixels per 3 big-endian words)
// and hands it to the display path one pixel per valid/ready handshake.
module sram_rgb_pixel_reader #(
    parameter int WORDS_PER_FRAME = 115200,
    parameter int FIFO_DEPTH      = 8,
    parameter int READ_LATENCY    = 2
) (
    input  logic        clock_50,
    input  logic        Resetn,
    input  logic        start,
    input  logic [17:0] base_address,
    output logic [17:0] SRAM_address,
    output logic        SRAM_we_n,
    input  logic [15:0] SRAM_read_data,
    output logic        pixel_valid,
    input  logic        pixel_ready,
    output logic [7:0]  pixel_R,
    output logic [7:0]  pixel_G,
    output logic [7:0]  pixel_B,
    output logic        busy,
    output logic        frame_done,
    output logic [1:0]  debug_state
);

    localparam int PIXELS = 2 * WORDS_PER_FRAME / 3;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  state;
    logic [17:0]             base_reg;
    logic [16:0]             word_cnt;
    logic [16:0]             pixel_cnt;
    logic [READ_LATENCY-1:0] inflight_sr;
    logic [15:0]             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W-1:0]        wr_ptr;
    logic [CNT_W-1:0]        fifo_count;
    logic                    phase;
    logic [7:0]              carry;

    logic [CNT_W-1:0]        inflight;
    logic [CNT_W:0]          credit_used;
    logic                    issue;
    logic                    push;
    logic [CNT_W-1:0]        need;
    logic [CNT_W-1:0]        pop_cnt;
    logic                    load;
    logic                    accept;
    logic                    last_accept;
    logic [15:0]             word0;
    logic [15:0]             word1;

    // Handshake: a pixel transfers on any rising edge where pixel_valid and
    // pixel_ready are both 1; pixel_valid never drops and data never changes
    // until that transfer happens.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + CNT_W'(inflight_sr[i]);
        end
        credit_used = {1'b0, fifo_count} + {1'b0, inflight};
        issue       = (state == S_FETCH) && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
        push        = inflight_sr[READ_LATENCY-1];
        need        = phase ? CNT_W'(1) : CNT_W'(2);
        load        = (state != S_IDLE) && (!pixel_valid || pixel_ready) && (fifo_count >= need);
        pop_cnt     = load ? need : '0;
        accept      = pixel_valid && pixel_ready;
        last_accept = accept && (pixel_cnt == 17'(PIXELS - 1));
        word0       = fifo_mem[rd_ptr];
        word1       = fifo_mem[rd_ptr + PTR_W'(1)];
    end

    assign SRAM_we_n   = 1'b1;
    assign debug_state = state;

    // Word buffer storage needs no reset; occupancy is tracked by fifo_count.
    always_ff @(posedge clock_50) begin
        if (push) begin
            fifo_mem[wr_ptr] <= SRAM_read_data;
        end
    end

    always_ff @(posedge clock_50) begin
        if (!Resetn) begin
            state        <= S_IDLE;
            base_reg     <= '0;
            word_cnt     <= '0;
            pixel_cnt    <= '0;
            inflight_sr  <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            fifo_count   <= '0;
            phase        <= 1'b0;
            carry        <= '0;
            SRAM_address <= '0;
            pixel_valid  <= 1'b0;
            pixel_R      <= '0;
            pixel_G      <= '0;
            pixel_B      <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done     <= 1'b0;
            inflight_sr[0] <= issue;
            for (int i = 1; i < READ_LATENCY; i++) begin
                inflight_sr[i] <= inflight_sr[i-1];
            end

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr     <= rd_ptr + PTR_W'(pop_cnt);
            fifo_count <= fifo_count + CNT_W'(push) - pop_cnt;

            if (issue) begin
                SRAM_address <= base_reg + {1'b0, word_cnt};
                word_cnt     <= word_cnt + 17'd1;
            end

            // Phase 0 spans two words and leaves one byte behind for phase 1.
            if (load) begin
                if (!phase) begin
                    {pixel_R, pixel_G, pixel_B} <= {word0, word1[15:8]};
                    carry                       <= word1[7:0];
                end else begin
                    {pixel_R, pixel_G, pixel_B} <= {carry, word0};
                end
                phase       <= ~phase;
                pixel_valid <= 1'b1;
            end else if (accept) begin
                pixel_valid <= 1'b0;
            end

            if (accept) begin
                pixel_cnt <= pixel_cnt + 17'd1;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_reg  <= base_address;
                        word_cnt  <= '0;
                        pixel_cnt <= '0;
                        phase     <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (issue && (word_cnt == 17'(WORDS_PER_FRAME - 1))) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                end
                default: state <= S_IDLE;
            endcase

            if (last_accept) begin
                state      <= S_IDLE;
                busy       <= 1'b0;
                frame_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_rgb_pixel_reader.sv
// Directed bench: a 6-word instance for ordering/reset cases and a 48-word
// instance for credit-limited backpressure and random-ready streaming.
module tb_sram_rgb_pixel_reader;

    logic        clock_50;
    logic        Resetn;

    logic        s_start, b_start;
    logic [17:0] s_base, b_base;
    logic [17:0] s_addr, b_addr;
    logic        s_we_n, b_we_n;
    logic [15:0] s_rdata, b_rdata;
    logic        s_valid, b_valid;
    logic        s_ready, b_ready;
    logic [7:0]  s_r, s_g, s_b, b_r, b_g, b_b;
    logic        s_busy, b_busy;
    logic        s_done, b_done;
    logic [1:0]  s_state, b_state;

    int checks = 0;
    int failures = 0;

    logic [23:0] s_exp_q[$];
    logic [23:0] b_exp_q[$];
    int          s_acc_cnt = 0, s_done_cnt = 0, s_addr_cnt = 0;
    int          b_done_cnt = 0, b_addr_cnt = 0;
    logic [17:0] s_addr_exp = '0, b_addr_exp = '0;
    logic [17:0] s_addr_last = '0, b_addr_last = '0;
    logic        we_n_bad = 1'b0;

    sram_rgb_pixel_reader #(.WORDS_PER_FRAME(6)) u_small (
        .clock_50(clock_50), .Resetn(Resetn), .start(s_start), .base_address(s_base),
        .SRAM_address(s_addr), .SRAM_we_n(s_we_n), .SRAM_read_data(s_rdata),
        .pixel_valid(s_valid), .pixel_ready(s_ready),
        .pixel_R(s_r), .pixel_G(s_g), .pixel_B(s_b),
        .busy(s_busy), .frame_done(s_done), .debug_state(s_state)
    );

    sram_rgb_pixel_reader #(.WORDS_PER_FRAME(48)) u_big (
        .clock_50(clock_50), .Resetn(Resetn), .start(b_start), .base_address(b_base),
        .SRAM_address(b_addr), .SRAM_we_n(b_we_n), .SRAM_read_data(b_rdata),
        .pixel_valid(b_valid), .pixel_ready(b_ready),
        .pixel_R(b_r), .pixel_G(b_g), .pixel_B(b_b),
        .busy(b_busy), .frame_done(b_done), .debug_state(b_state)
    );

    // Clock / reset
    initial clock_50 = 1'b0;
    always #10 clock_50 = ~clock_50;

    function automatic logic [15:0] word_at(input logic [17:0] a);
        case (a)
            18'd100: return 16'h1122;
            18'd101: return 16'h3344;
            18'd102: return 16'h5566;
            18'd103: return 16'h7788;
            18'd104: return 16'h99AA;
            18'd105: return 16'hBBCC;
            default: return {a[7:0] ^ 8'hA5, a[15:8] + a[7:0] + 8'h3C};
        endcase
    endfunction

    // SRAM model: data sampled by the reader two edges after the address edge.
    always @(posedge clock_50) begin
        s_rdata <= word_at(s_addr);
        b_rdata <= word_at(b_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard / monitors
    always @(negedge clock_50) begin
        if (Resetn) begin
            if (s_valid && s_ready) begin
                s_acc_cnt++;
                if (s_exp_q.size() == 0) check("s_extra_pixel", 32'(1), 32'(0));
                else check("s_pixel", 32'({s_r, s_g, s_b}), 32'(s_exp_q.pop_front()));
            end
            if (b_valid && b_ready) begin
                if (b_exp_q.size() == 0) check("b_extra_pixel", 32'(1), 32'(0));
                else check("b_pixel", 32'({b_r, b_g, b_b}), 32'(b_exp_q.pop_front()));
            end
            if (s_done) begin
                s_done_cnt++;
                check("s_busy_at_done", 32'(s_busy), 32'(0));
            end
            if (b_done) begin
                b_done_cnt++;
                check("b_busy_at_done", 32'(b_busy), 32'(0));
            end
            if (s_busy && s_addr != s_addr_last) begin
                check("s_addr", 32'(s_addr), 32'(s_addr_exp));
                s_addr_exp++;
                s_addr_cnt++;
            end
            if (b_busy && b_addr != b_addr_last) begin
                check("b_addr", 32'(b_addr), 32'(b_addr_exp));
                b_addr_exp++;
                b_addr_cnt++;
            end
            if (!s_we_n || !b_we_n) we_n_bad = 1'b1;
        end
        s_addr_last = s_addr;
        b_addr_last = b_addr;
    end

    task automatic load_b_exp(input logic [17:0] base, input int nwords);
        logic [7:0]  bytes[$];
        logic [15:0] w;
        b_exp_q.delete();
        for (int i = 0; i < nwords; i++) begin
            w = word_at(base + 18'(i));
            bytes.push_back(w[15:8]);
            bytes.push_back(w[7:0]);
        end
        for (int k = 0; k + 2 < bytes.size(); k += 3) begin
            b_exp_q.push_back({bytes[k], bytes[k+1], bytes[k+2]});
        end
    endtask

    task automatic start_small;
        s_exp_q    = {24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
        s_addr_exp = 18'd100;
        s_ready    = 1'b1;
        s_base     = 18'd100;
        s_start    = 1'b1;
        @(posedge clock_50); #1;
        s_start = 1'b0;
        s_base  = 18'd0;
    endtask

    task automatic run_small_frame(input bit poke_start);
        int lat;
        int done0;
        int addr0;
        int n;
        done0 = s_done_cnt;
        addr0 = s_addr_cnt;
        start_small();
        lat = 0;
        do begin
            @(posedge clock_50); #1;
            lat++;
        end while (!s_valid && lat < 40);
        check("s_first_valid", 32'(s_valid), 32'(1));
        check("s_first_latency_min", 32'(lat >= 5), 32'(1));
        if (poke_start) begin
            repeat (2) @(posedge clock_50);
            #1;
            s_start = 1'b1;
            s_base  = 18'd500;
            @(posedge clock_50); #1;
            s_start = 1'b0;
            s_base  = 18'd0;
        end
        n = 0;
        while (s_done_cnt == done0 && n < 100) begin
            @(posedge clock_50); #1;
            n++;
        end
        repeat (3) @(posedge clock_50);
        #1;
        check("s_done_pulses", 32'(s_done_cnt - done0), 32'(1));
        check("s_queue_empty", 32'(s_exp_q.size()), 32'(0));
        check("s_words_issued", 32'(s_addr_cnt - addr0), 32'(6));
        check("s_last_addr", 32'(s_addr), 32'(105));
        check("s_busy_after", 32'(s_busy), 32'(0));
        check("s_state_after", 32'(s_state), 32'(0));
    endtask

    initial begin
        int          n;
        int          done0;
        logic [23:0] held;
        logic        bad;

        // Reset with start held high
        Resetn  = 1'b0;
        s_start = 1'b1;
        b_start = 1'b1;
        s_base  = 18'd77;
        b_base  = 18'd77;
        s_ready = 1'b0;
        b_ready = 1'b0;
        repeat (3) @(posedge clock_50);
        #1;
        check("rst_s_valid", 32'(s_valid), 32'(0));
        check("rst_s_addr", 32'(s_addr), 32'(0));
        check("rst_s_we_n", 32'(s_we_n), 32'(1));
        check("rst_s_busy", 32'(s_busy), 32'(0));
        check("rst_s_done", 32'(s_done), 32'(0));
        check("rst_s_rgb", 32'({s_r, s_g, s_b}), 32'(0));
        check("rst_s_state", 32'(s_state), 32'(0));
        check("rst_b_valid", 32'(b_valid), 32'(0));
        check("rst_b_busy", 32'(b_busy), 32'(0));
        check("rst_b_addr", 32'(b_addr), 32'(0));
        s_start = 1'b0;
        b_start = 1'b0;
        s_base  = 18'd0;
        b_base  = 18'd0;
        @(posedge clock_50); #1;
        Resetn = 1'b1;
        @(posedge clock_50); #1;

        // Small frame, then the same frame with a start pulse mid-frame
        run_small_frame(1'b0);
        run_small_frame(1'b1);

        // Reset after three pixels accepted, then a clean re-read
        s_acc_cnt = 0;
        start_small();
        n = 0;
        while (s_acc_cnt < 3 && n < 100) begin
            @(posedge clock_50); #1;
            n++;
        end
        check("s_three_accepted", 32'(s_acc_cnt), 32'(3));
        s_ready = 1'b0;
        Resetn  = 1'b0;
        done0   = s_done_cnt;
        @(posedge clock_50); #1;
        check("mid_rst_valid", 32'(s_valid), 32'(0));
        check("mid_rst_busy", 32'(s_busy), 32'(0));
        check("mid_rst_state", 32'(s_state), 32'(0));
        repeat (2) @(posedge clock_50);
        #1;
        check("mid_rst_no_done", 32'(s_done_cnt - done0), 32'(0));
        s_exp_q.delete();
        Resetn = 1'b1;
        @(posedge clock_50); #1;
        run_small_frame(1'b0);

        // Backpressure on a 48-word frame, then random ready
        load_b_exp(18'd1000, 48);
        b_addr_exp = 18'd1000;
        done0      = b_done_cnt;
        b_ready    = 1'b0;
        b_base     = 18'd1000;
        b_start    = 1'b1;
        @(posedge clock_50); #1;
        b_start = 1'b0;
        b_base  = 18'd0;
        n = 0;
        while (!b_valid && n < 50) begin
            @(posedge clock_50); #1;
            n++;
        end
        check("b_first_valid", 32'(b_valid), 32'(1));
        held = {b_r, b_g, b_b};
        check("b_first_pixel", 32'(held), 32'(b_exp_q[0]));
        bad = 1'b0;
        repeat (40) begin
            @(posedge clock_50); #1;
            if (!b_valid || {b_r, b_g, b_b} != held) bad = 1'b1;
        end
        check("b_hold_stable", 32'(bad), 32'(0));
        check("b_stall_addr", 32'(b_addr), 32'(1009));
        check("b_stall_issued", 32'(b_addr_cnt), 32'(10));
        n = 0;
        while (b_done_cnt == done0 && n < 2000) begin
            b_ready = 1'($urandom_range(0, 1));
            @(posedge clock_50); #1;
            n++;
        end
        b_ready = 1'b1;
        repeat (3) @(posedge clock_50);
        #1;
        check("b_done_pulses", 32'(b_done_cnt - done0), 32'(1));
        check("b_queue_empty", 32'(b_exp_q.size()), 32'(0));
        check("b_words_issued", 32'(b_addr_cnt), 32'(48));
        check("b_last_addr", 32'(b_addr), 32'(1047));
        check("b_busy_after", 32'(b_busy), 32'(0));
        check("we_n_never_low", 32'(we_n_bad), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_rgb_pixel_reader.md
Name: sram_rgb_pixel_reader

Overview:
- Read-side counterpart to the milestone 1 RGB writer: fetches the packed RGB frame from external SRAM (default region 146944..262143) and delivers RGB888 pixels, one per valid/ready handshake, to the VGA / display path.
- SRAM layout: 3 bytes per pixel, 2 bytes per 16-bit word, big-endian (high byte first); 3 words hold 2 pixels.
- Sits between the SRAM controller read port and the VGA pixel consumer; never writes SRAM.

Parameters:
- WORDS_PER_FRAME, 115200, number of 16-bit words per frame (3*320*240/2); must be a multiple of 3.
- FIFO_DEPTH, 8, word buffer entries (power of 2, >= READ_LATENCY+2).
- READ_LATENCY, 2, cycles from SRAM_address issue to valid SRAM_read_data.

Ports:
- Clock  in  1  system clock (50 MHz); all logic on its rising edge.
- Resetn  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame read when idle.
- base_address  in  18  first word address; sampled on accepted start.
- SRAM_address  out  18  read address to SRAM controller.
- SRAM_we_n  out  1  held 1 (read only).
- SRAM_read_data  in  16  read data, valid READ_LATENCY cycles after address.
- pixel_valid  out  1  pixel_R/G/B hold a valid pixel.
- pixel_ready  in  1  consumer accepts the pixel when valid & ready.
- pixel_R  out  8  red.
- pixel_G  out  8  green.
- pixel_B  out  8  blue.
- busy  out  1  high from accepted start until frame_done.
- frame_done  out  1  one-cycle pulse on acceptance of the last pixel.

Behaviour:
- Reset (Resetn=0 at a clock edge): state S_IDLE; SRAM_address=0; SRAM_we_n=1; pixel_valid=0; pixel_R/G/B=0; busy=0; frame_done=0; FIFO empty; in-flight pipeline cleared; counters 0. Reset mid-frame discards all in-flight reads and buffered pixels with no frame_done.
- States: S_IDLE -> (start) S_FETCH -> (all words issued) S_DRAIN -> (last pixel accepted) S_IDLE.
- start in S_IDLE: latch base_address, word_cnt=0, busy=1 next cycle. start while busy: ignored.
- Read issue in S_FETCH: issue when fifo_count + inflight < FIFO_DEPTH. On issue, SRAM_address = base + word_cnt, word_cnt increments, and inflight is tracked by a READ_LATENCY-deep valid shift register. No issue means SRAM_address holds its last value.
- Last issue (word_cnt = WORDS_PER_FRAME-1): go to S_DRAIN. No address beyond base+WORDS_PER_FRAME-1 is ever driven.
- Return data: pushed into the FIFO exactly READ_LATENCY cycles after issue. The credit rule guarantees the FIFO never overflows. Simultaneous push and pop is allowed.
- Unpacker: a 2-phase state with an 8-bit carry byte.
  - Phase 0 needs 2 words (w0, w1): pixel = {w0[15:8], w0[7:0], w1[15:8]}; carry = w1[7:0]; pops 2 words.
  - Phase 1 needs 1 word (w2): pixel = {carry, w2[15:8], w2[7:0]}; pops 1 word.
  - A new pixel loads into the output register when it is empty, or when it is being accepted this cycle and enough words are present. This gives one pixel per cycle at full throughput.
- Output: pixel_R/G/B stable while pixel_valid=1 and pixel_ready=0. pixel_valid stays 1 until accepted.
- Latency: first pixel_valid no earlier than 2+READ_LATENCY+1 cycles after start (two words plus output register).
- Pixel count: 2*WORDS_PER_FRAME/3 pixels (76800 default). On acceptance of the last one: frame_done=1 for exactly one cycle, busy=0 and state S_IDLE the same edge. A start in the cycle after frame_done is accepted.
- Counters: word_cnt 17 bits, pixel_cnt 17 bits, no wrap. Address addition is 18-bit; base+WORDS_PER_FRAME ≤ 262144 is the caller's responsibility.

Test Plan:
- Reset: hold Resetn=0 for 3 cycles with start=1 -> all outputs at reset values, SRAM_we_n=1, no address change, busy=0.
- Small frame: WORDS_PER_FRAME=6, base_address=100, SRAM[100..105]=1122,3344,5566,7788,99AA,BBCC, pixel_ready=1 -> addresses 100..105 in order, pixels (11,22,33),(44,55,66),(77,88,99),(AA,BB,CC), one frame_done pulse, busy drops.
- Backpressure: default params, pixel_ready=0 for 40 cycles after the first pixel_valid -> reads stop with fifo_count+inflight = FIFO_DEPTH, pixel held unchanged. Release ready -> pixel sequence continues with no loss or duplication.
- Ignored start: pulse start 10 cycles into a 6-word frame with base_address=500 -> no address ≥500 issued, output identical to the small-frame case.
- Reset mid-frame: assert Resetn=0 after 3 pixels accepted -> pixel_valid=0, busy=0, no frame_done. A subsequent start re-reads from base with the correct first pixel.
- Full frame: base_address=146944, SRAM loaded from panda.sram_d0, random pixel_ready -> 76800 pixels matching file bytes in order, last address 262143, SRAM_we_n never 0.
